// File: rtl/ex_mem_reg.sv
// ex_mem_reg
//   EX->MEM pipeline register sitting directly after the ALU. Captures the ALU
//   result, the load/store and write-back controls and the store data of the
//   EX-stage instruction. It also owns the architectural Z/N/V flag register
//   and evaluates the decode-stage branch condition against those flags.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall             hold every register, flags included
//   flush             load a bubble; wins over stall
//   ex_valid          EX slot holds a real instruction
//   ex_alu_out        ALU result
//   ex_ovfl           ALU signed overflow (add/sub)
//   ex_alu_ctrl       ALU opcode, selects which flags are written
//   ex_flag_en        instruction may write flags
//   ex_rd, ex_reg_wr  write-back destination and enable
//   ex_mem_rd/wr      load / store enables
//   ex_store_data     store data
//   br_cond           branch condition code of the instruction in decode
//   mem_*             registered copies of the EX fields
//   flag_z/n/v        architectural flags
//   br_taken          combinational: br_cond satisfied by the registered flags
module ex_mem_reg #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_out,
    input  logic          ex_ovfl,
    input  logic [4:0]    ex_alu_ctrl,
    input  logic          ex_flag_en,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_wr,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic [DW-1:0] ex_store_data,
    input  logic [2:0]    br_cond,
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_out,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_wr,
    output logic          mem_mem_rd,
    output logic          mem_mem_wr,
    output logic [DW-1:0] mem_store_data,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_v,
    output logic          br_taken
);

    logic accept;
    logic upd_z;
    logic upd_nv;

    assign accept = ex_valid & ~stall & ~flush;

    // Opcode class decides which flags an accepted flag-writer may touch:
    // add/sub write Z, N and V; logic and shift ops write Z only.
    always_comb begin
        upd_z  = 1'b0;
        upd_nv = 1'b0;
        case (ex_alu_ctrl)
            5'h00, 5'h01: begin
                upd_z  = 1'b1;
                upd_nv = 1'b1;
            end
            5'h02, 5'h03, 5'h04, 5'h05, 5'h06: begin
                upd_z  = 1'b1;
            end
            default: begin
                upd_z  = 1'b0;
                upd_nv = 1'b0;
            end
        endcase
    end

    // Pipeline fields. Control and write-back fields are gated with ex_valid
    // so an empty EX slot arrives in MEM as a clean bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= '0;
            mem_rd         <= '0;
            mem_reg_wr     <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= '0;
            mem_rd         <= '0;
            mem_reg_wr     <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_alu_out    <= ex_alu_out;
            mem_rd         <= ex_valid ? ex_rd : '0;
            mem_reg_wr     <= ex_valid & ex_reg_wr;
            mem_mem_rd     <= ex_valid & ex_mem_rd;
            mem_mem_wr     <= ex_valid & ex_mem_wr;
            mem_store_data <= ex_store_data;
        end
    end

    // Flags only change for an accepted instruction; flush and stall both
    // leave them untouched because accept is low in either case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (accept && ex_flag_en) begin
            if (upd_z) begin
                flag_z <= (ex_alu_out == '0);
            end
            if (upd_nv) begin
                flag_n <= ex_alu_out[DW-1];
                flag_v <= ex_ovfl;
            end
        end
    end

    // Registered flags only; a branch right after a flag writer is stalled
    // upstream, so no bypass from the EX stage is needed here.
    always_comb begin
        br_taken = 1'b0;
        case (br_cond)
            3'b000:  br_taken = ~flag_z;
            3'b001:  br_taken = flag_z;
            3'b010:  br_taken = ~flag_z & ~flag_n;
            3'b011:  br_taken = flag_n;
            3'b100:  br_taken = flag_z | ~flag_n;
            3'b101:  br_taken = flag_z | flag_n;
            3'b110:  br_taken = flag_v;
            default: br_taken = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg
//   Directed-vector bench for ex_mem_reg. Inputs are driven 1 ns after the
//   rising edge and outputs are sampled 1 ns after the next rising edge.
module tb_ex_mem_reg;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic        ex_ovfl;
    logic [4:0]  ex_alu_ctrl;
    logic        ex_flag_en;
    logic [3:0]  ex_rd;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [15:0] ex_store_data;
    logic [2:0]  br_cond;
    logic        mem_valid;
    logic [15:0] mem_alu_out;
    logic [3:0]  mem_rd;
    logic        mem_reg_wr;
    logic        mem_mem_rd;
    logic        mem_mem_wr;
    logic [15:0] mem_store_data;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic        br_taken;

    int checks;
    int failures;

    ex_mem_reg #(.DW(16), .RW(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_alu_out     (ex_alu_out),
        .ex_ovfl        (ex_ovfl),
        .ex_alu_ctrl    (ex_alu_ctrl),
        .ex_flag_en     (ex_flag_en),
        .ex_rd          (ex_rd),
        .ex_reg_wr      (ex_reg_wr),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_wr      (ex_mem_wr),
        .ex_store_data  (ex_store_data),
        .br_cond        (br_cond),
        .mem_valid      (mem_valid),
        .mem_alu_out    (mem_alu_out),
        .mem_rd         (mem_rd),
        .mem_reg_wr     (mem_reg_wr),
        .mem_mem_rd     (mem_mem_rd),
        .mem_mem_wr     (mem_mem_wr),
        .mem_store_data (mem_store_data),
        .flag_z         (flag_z),
        .flag_n         (flag_n),
        .flag_v         (flag_v),
        .br_taken       (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] ctrl, input logic [15:0] out,
                         input logic ov, input logic fen, input logic [3:0] rd,
                         input logic rw, input logic mr, input logic mw,
                         input logic [15:0] sd);
        ex_valid      = v;
        ex_alu_ctrl   = ctrl;
        ex_alu_out    = out;
        ex_ovfl       = ov;
        ex_flag_en    = fen;
        ex_rd         = rd;
        ex_reg_wr     = rw;
        ex_mem_rd     = mr;
        ex_mem_wr     = mw;
        ex_store_data = sd;
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n, input logic v);
        check({tag, ".z"}, {31'd0, flag_z}, {31'd0, z});
        check({tag, ".n"}, {31'd0, flag_n}, {31'd0, n});
        check({tag, ".v"}, {31'd0, flag_v}, {31'd0, v});
    endtask

    task automatic check_br(input string tag, input logic [2:0] cond, input logic exp);
        br_cond = cond;
        #1;
        check(tag, {31'd0, br_taken}, {31'd0, exp});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid"}, {31'd0, mem_valid}, 32'd0);
        check({tag, ".alu"}, {16'd0, mem_alu_out}, 32'd0);
        check({tag, ".rd"}, {28'd0, mem_rd}, 32'd0);
        check({tag, ".reg_wr"}, {31'd0, mem_reg_wr}, 32'd0);
        check({tag, ".mem_rd"}, {31'd0, mem_mem_rd}, 32'd0);
        check({tag, ".mem_wr"}, {31'd0, mem_mem_wr}, 32'd0);
        check({tag, ".sd"}, {16'd0, mem_store_data}, 32'd0);
        check_flags(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] reset_br;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        br_cond  = 3'b000;
        drive(1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 1'b1, 1'b1,
              4'($urandom), 1'b1, 1'b1, 1'b1, 16'($urandom));

        // Reset with live inputs: everything cleared, branch decode on Z=N=V=0.
        step();
        step();
        check_cleared("reset");
        // Expected br_taken per cond 7..0 with all flags 0: 1,0,0,1,0,1,0,1
        reset_br = 8'b1001_0101;
        for (int i = 0; i < 8; i++) begin
            check_br($sformatf("reset.br%0d", i), 3'(i), reset_br[i]);
        end

        rst_n = 1'b1;

        // Add producing zero with overflow.
        drive(1'b1, 5'h00, 16'h0000, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 16'hBEEF);
        step();
        check_flags("add0", 1'b1, 1'b0, 1'b1);
        check("add0.valid", {31'd0, mem_valid}, 32'd1);
        check("add0.alu", {16'd0, mem_alu_out}, 32'h0000);
        check("add0.rd", {28'd0, mem_rd}, 32'd3);
        check("add0.reg_wr", {31'd0, mem_reg_wr}, 32'd1);
        check("add0.sd", {16'd0, mem_store_data}, 32'hBEEF);
        check_br("add0.br_eq", 3'b001, 1'b1);
        check_br("add0.br_ov", 3'b110, 1'b1);
        check_br("add0.br_ne", 3'b000, 1'b0);

        // Sub producing 0x8000 sets N, clears Z and V.
        drive(1'b1, 5'h01, 16'h8000, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_flags("sub", 1'b0, 1'b1, 1'b0);
        check_br("sub.br_lt", 3'b011, 1'b1);

        // Xor with ovfl=1: only Z written, N and V keep 1 and 0.
        drive(1'b1, 5'h04, 16'h0005, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_flags("xor", 1'b0, 1'b1, 1'b0);
        check("xor.alu", {16'd0, mem_alu_out}, 32'h0005);
        check_br("xor.br_lt", 3'b011, 1'b1);
        check_br("xor.br_gt", 3'b010, 1'b0);
        check_br("xor.br_le", 3'b101, 1'b1);

        // Stall three cycles while EX presents flag-writing adds.
        stall = 1'b1;
        drive(1'b1, 5'h00, 16'h1111, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d.alu", i), {16'd0, mem_alu_out}, 32'h0005);
            check($sformatf("stall%0d.rd", i), {28'd0, mem_rd}, 32'd5);
            check($sformatf("stall%0d.mem_wr", i), {31'd0, mem_mem_wr}, 32'd0);
            check_flags($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b0);
            ex_alu_out = 16'h2222;
        end
        stall = 1'b0;

        // Add of 0x1111 after the stall releases.
        drive(1'b1, 5'h00, 16'h1111, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 16'h1234);
        step();
        check_flags("add1111", 1'b0, 1'b0, 1'b0);
        check("add1111.alu", {16'd0, mem_alu_out}, 32'h1111);
        check("add1111.mem_rd", {31'd0, mem_mem_rd}, 32'd1);
        check("add1111.mem_wr", {31'd0, mem_mem_wr}, 32'd1);
        check("add1111.sd", {16'd0, mem_store_data}, 32'h1234);

        // Flush together with stall: bubble loaded, zero result must not set Z.
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 5'h00, 16'h0000, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 16'h5555);
        step();
        flush = 1'b0;
        stall = 1'b0;
        check("flush.valid", {31'd0, mem_valid}, 32'd0);
        check("flush.reg_wr", {31'd0, mem_reg_wr}, 32'd0);
        check("flush.alu", {16'd0, mem_alu_out}, 32'h0000);
        check("flush.mem_wr", {31'd0, mem_mem_wr}, 32'd0);
        check("flush.sd", {16'd0, mem_store_data}, 32'h0000);
        check_flags("flush", 1'b0, 1'b0, 1'b0);

        // llb (0x8) with zero result: no flag change, fields still pass.
        drive(1'b1, 5'h08, 16'h0000, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_flags("llb", 1'b0, 1'b0, 1'b0);
        check("llb.alu", {16'd0, mem_alu_out}, 32'h0000);
        check("llb.reg_wr", {31'd0, mem_reg_wr}, 32'd1);
        check("llb.rd", {28'd0, mem_rd}, 32'd9);
        check("llb.valid", {31'd0, mem_valid}, 32'd1);

        // Code 0x7 sits outside the logic range: no flag change.
        drive(1'b1, 5'h07, 16'h0000, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check_flags("op7", 1'b0, 1'b0, 1'b0);

        // Add with flag_en=0: flags untouched.
        drive(1'b1, 5'h00, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_flags("noen", 1'b0, 1'b0, 1'b0);

        // Invalid slot: control bits gated, no flag write.
        drive(1'b0, 5'h00, 16'h0000, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 16'h0000);
        step();
        check("inval.valid", {31'd0, mem_valid}, 32'd0);
        check("inval.reg_wr", {31'd0, mem_reg_wr}, 32'd0);
        check("inval.mem_rd", {31'd0, mem_mem_rd}, 32'd0);
        check("inval.mem_wr", {31'd0, mem_mem_wr}, 32'd0);
        check("inval.rd", {28'd0, mem_rd}, 32'd0);
        check_flags("inval", 1'b0, 1'b0, 1'b0);

        // sra (0x6) with zero result: Z set, N held.
        drive(1'b1, 5'h06, 16'h0000, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_flags("sra", 1'b1, 1'b0, 1'b0);
        check_br("sra.br_ge", 3'b100, 1'b1);

        // Sub 0xFFFF with overflow, then async reset mid-cycle.
        drive(1'b1, 5'h01, 16'hFFFF, 1'b1, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 16'hA5A5);
        step();
        check_flags("subneg", 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        check_br("midrst.br_ov", 3'b110, 1'b0);
        step();
        rst_n = 1'b1;

        // First edge after release loads normally.
        drive(1'b1, 5'h0A, 16'h00F0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b1, 16'h0F0F);
        step();
        check("post.valid", {31'd0, mem_valid}, 32'd1);
        check("post.alu", {16'd0, mem_alu_out}, 32'h00F0);
        check("post.rd", {28'd0, mem_rd}, 32'd11);
        check("post.mem_wr", {31'd0, mem_mem_wr}, 32'd1);
        check("post.sd", {16'd0, mem_store_data}, 32'h0F0F);
        check_flags("post", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
